// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer that drives an external Montgomery multiplier.
// Define MONT_EXP_TIMEOUT_EN to build the WAIT-state watchdog and the sticky err flag.
module mont_exp_ctrl #(
    parameter int DATA_W  = 1024,
    parameter int LEN_W   = 11,
    parameter int TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_r,
    input  logic [DATA_W-1:0] in_m,
    input  logic [DATA_W-1:0] in_e,
    input  logic [LEN_W-1:0]  in_e_len,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic              mm_start,
    output logic [DATA_W-1:0] mm_a,
    output logic [DATA_W-1:0] mm_b,
    output logic [DATA_W-1:0] mm_m,
    input  logic [DATA_W-1:0] mm_result,
    input  logic              mm_done,
    output logic [2:0]        state_dbg
);

    // Multiplier handshake: mm_start is high for the single ISSUE cycle; mm_a/mm_b/mm_m
    // stay constant until mm_done is sampled in the matching WAIT state, the only place it counts.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SQ_ISSUE  = 3'd1,
        SQ_WAIT   = 3'd2,
        MUL_ISSUE = 3'd3,
        MUL_WAIT  = 3'd4,
        FIN       = 3'd5
    } state_t;

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [LEN_W:0] LEN_MAX = (LEN_W+1)'(DATA_W);
    localparam logic [LEN_W:0] LEN_ONE = (LEN_W+1)'(1);

    state_t             state;
    state_t             state_nx;
    logic [DATA_W-1:0]  x_q;
    logic [DATA_W-1:0]  m_q;
    logic [DATA_W-1:0]  e_q;
    logic [DATA_W-1:0]  acc;
    logic [IDX_W-1:0]   idx;
    logic [LEN_W:0]     len_eff;
    logic               in_wait;
    logic               timeout_hit;

    assign len_eff   = ({1'b0, in_e_len} > LEN_MAX) ? LEN_MAX : {1'b0, in_e_len};
    assign in_wait   = (state == SQ_WAIT) || (state == MUL_WAIT);
    assign busy      = (state != IDLE);
    assign mm_start  = (state == SQ_ISSUE) || (state == MUL_ISSUE);
    assign mm_a      = acc;
    assign mm_b      = ((state == MUL_ISSUE) || (state == MUL_WAIT)) ? x_q : acc;
    assign mm_m      = m_q;
    assign state_dbg = state;

`ifdef MONT_EXP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Counts WAIT cycles without a completion; restarts for every multiplier request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (in_wait && !mm_done) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout_hit = in_wait && !mm_done && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (state == IDLE && start) begin
            err <= 1'b0;
        end else if (timeout_hit) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (len_eff == '0) ? FIN : SQ_ISSUE;
                end
            end
            SQ_ISSUE:  state_nx = SQ_WAIT;
            SQ_WAIT: begin
                if (mm_done) begin
                    if (e_q[idx]) begin
                        state_nx = MUL_ISSUE;
                    end else if (idx == '0) begin
                        state_nx = FIN;
                    end else begin
                        state_nx = SQ_ISSUE;
                    end
                end else if (timeout_hit) begin
                    state_nx = IDLE;
                end
            end
            MUL_ISSUE: state_nx = MUL_WAIT;
            MUL_WAIT: begin
                if (mm_done) begin
                    state_nx = (idx == '0) ? FIN : SQ_ISSUE;
                end else if (timeout_hit) begin
                    state_nx = IDLE;
                end
            end
            FIN:       state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // idx walks the exponent from its top processed bit down to bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q    <= '0;
            m_q    <= '0;
            e_q    <= '0;
            acc    <= '0;
            idx    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == FIN) || timeout_hit;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_q <= in_x;
                        m_q <= in_m;
                        e_q <= in_e;
                        acc <= in_r;
                        idx <= IDX_W'(len_eff - LEN_ONE);
                    end
                end
                SQ_WAIT: begin
                    if (mm_done) begin
                        acc <= mm_result;
                        if (!e_q[idx] && idx != '0) begin
                            idx <= idx - IDX_W'(1);
                        end
                    end
                end
                MUL_WAIT: begin
                    if (mm_done) begin
                        acc <= mm_result;
                        if (idx != '0) begin
                            idx <= idx - IDX_W'(1);
                        end
                    end
                end
                FIN:     result <= acc;
                default: ;
            endcase
            if (timeout_hit) begin
                result <= '0;
            end
        end
    end

endmodule

// File: doc/mont_exp_ctrl.md
MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 SHALL have parameters: DATA_W, default 1024, operand/modulus width; LEN_W, default 11, width of exponent-length field; TIMEOUT, default 4095, watchdog limit in cycles.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  one-cycle request, sampled only in IDLE.
REQ-005 SHALL have port: in_x  input  DATA_W  base, Montgomery domain.
REQ-006 SHALL have port: in_r  input  DATA_W  R mod M (Montgomery one).
REQ-007 SHALL have port: in_m  input  DATA_W  modulus.
REQ-008 SHALL have port: in_e  input  DATA_W  exponent.
REQ-009 SHALL have port: in_e_len  input  LEN_W  number of exponent bits to process, 0..DATA_W.
REQ-010 SHALL have port: result  output  DATA_W  x^e, Montgomery domain.
REQ-011 SHALL have ports: done  output  1  one-cycle completion pulse; busy  output  1  high outside IDLE; err  output  1  sticky timeout flag.
REQ-012 SHALL have ports: mm_start  output  1; mm_a, mm_b, mm_m  output  DATA_W; mm_result  input  DATA_W; mm_done  input  1; together these drive an external Montgomery multiplier as its initiator.

Function
REQ-013 SHALL implement states IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, FIN.
REQ-014 IDLE with start=1 SHALL latch in_x, in_m, in_e, set acc=in_r and idx=in_e_len-1, then go to FIN if in_e_len=0, else to SQ_ISSUE.
REQ-015 mm_start SHALL be high for exactly the one cycle spent in SQ_ISSUE or MUL_ISSUE; the next state is the matching WAIT state.
REQ-016 mm_a SHALL equal acc; mm_b SHALL equal acc in SQ states and latched x in MUL states; mm_m SHALL equal latched m; all three SHALL be stable from the issue cycle until mm_done is sampled.
REQ-017 SQ_WAIT with mm_done=1 SHALL set acc=mm_result and go to MUL_ISSUE if e[idx]=1; otherwise go to FIN if idx=0, else decrement idx and go to SQ_ISSUE.
REQ-018 MUL_WAIT with mm_done=1 SHALL set acc=mm_result and go to FIN if idx=0, else decrement idx and go to SQ_ISSUE.
REQ-019 mm_done SHALL be ignored outside the WAIT states, including the issue cycle.
REQ-020 FIN SHALL assert done for one cycle with result=acc, then return to IDLE; result SHALL hold until the next start is accepted.
REQ-021 start SHALL be ignored while busy=1; the operand registers SHALL NOT change.
REQ-022 The number of mm_start pulses SHALL equal in_e_len plus popcount(in_e[in_e_len-1:0]).
REQ-023 in_e_len > DATA_W SHALL be treated as DATA_W.

Reset
REQ-024 reset=1 SHALL asynchronously force IDLE and clear to 0: done, busy, mm_start, err, result, acc, idx.
REQ-025 Reset during any WAIT state SHALL abandon the operation; a subsequent mm_done SHALL be ignored, and no done pulse SHALL be produced.

Configuration
REQ-026 With MONT_EXP_TIMEOUT_EN defined, a counter SHALL run in the WAIT states; if it reaches TIMEOUT without mm_done, the block SHALL set err=1, pulse done with result=0, and return to IDLE.
REQ-027 err SHALL clear only on reset or on the next accepted start.
REQ-028 Without MONT_EXP_TIMEOUT_EN, no counter SHALL be synthesised, err SHALL be tied to 0, and the WAIT states SHALL wait indefinitely.

Verification
REQ-029 in_e_len=0, start -> no mm_start; done 2 cycles after the start edge; result=in_r.
REQ-030 in_e=1, in_e_len=1, behavioural multiplier model with latency 8 -> exactly 2 mm_start pulses (square, then multiply); result=in_x.
REQ-031 in_e=5, in_e_len=3, small modulus m=13 under the model -> 5 mm_start pulses in order SQ,MUL,SQ,SQ,MUL; result matches the model's x^5 value.
REQ-032 start re-asserted while busy, plus a spurious mm_done during the issue cycle -> no change to the mm_start count or to result.
REQ-033 reset pulsed during MUL_WAIT, then a late mm_done -> IDLE, busy=0, no done pulse; a fresh run afterwards is correct.
REQ-034 MONT_EXP_TIMEOUT_EN defined, TIMEOUT=16, model never returns mm_done -> done and err high exactly 16 cycles after entering SQ_WAIT; result=0.
